// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RV32I control unit: state encoding,
// opcodes and the mux/ALU select encodings driven onto the datapath.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mc_immdec.sv
// Opcode to immediate-format decode; kept separate so a pipelined decoder can reuse it.
module mc_immdec
    import mc_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for a shared-memory multicycle RV32I datapath, with a
// memory-ready stall watchdog and illegal-opcode flag.
module mc_controller
    import mc_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       illegal_instr,
    output logic       mem_timeout,
    output logic [3:0] state_o
);

    localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_WAIT_MAX);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_inc;
    logic          waiting;
    logic          pc_update;
    logic          branch;
    logic          ir_write;

    assign waiting  = ((state == S_FETCH) || (state == S_MEMREAD) ||
                       (state == S_MEMWRITE)) && !mem_ready;
    assign wait_inc = wait_cnt + CW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                S_FETCH:    state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXECR;
                        OP_I:         state <= S_EXECI;
                        OP_JAL:       state <= S_JAL;
                        OP_BEQ:       state <= S_BEQ;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state <= mem_ready ? S_MEMWB : S_MEMREAD;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: state <= mem_ready ? S_FETCH : S_MEMWRITE;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_BEQ:      state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase

            // Counter saturates; the flag stays set and the FSM keeps waiting.
            if (waiting) begin
                if (wait_cnt != WAIT_MAX) wait_cnt <= wait_inc;
                if ((MEM_WAIT_MAX != 0) && (wait_inc == WAIT_MAX)) mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write      = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        illegal_instr = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_B;
        ALUOp         = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_write  = mem_ready;
                pc_update = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA       = SRCA_OLDPC;
                ALUSrcB       = SRCB_IMM;
                illegal_instr = !is_supported(op);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            // The write strobe is held for the whole access, not gated by mem_ready.
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_A;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_A;
                ALUOp   = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // FETCH enables follow mem_ready, so they must be masked while reset is held.
    assign PCWrite = reset_n & (pc_update | (branch & Zero));
    assign IRWrite = reset_n & ir_write;
    assign state_o = state;

    mc_immdec u_immdec (
        .op      (op),
        .imm_src (ImmSrc)
    );

endmodule
